// File: rtl/dmem_responder_if.sv
// Memory-stage request/response bundle between the pipeline
// and the data-memory responder.
interface dmem_responder_if;
    logic        memreq;
    logic        memwrite;
    logic        byteen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;

    modport master (
        output memreq,
        output memwrite,
        output byteen,
        output addr,
        output wdata,
        input  rdata,
        input  stall,
        input  misalign
    );

    modport slave (
        input  memreq,
        input  memwrite,
        input  byteen,
        input  addr,
        input  wdata,
        output rdata,
        output stall,
        output misalign
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data RAM with a programmable wait latency;
// stalls the pipeline while a load/store is in flight.
module dmem_responder #(
    parameter int AW      = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          be_q, be_d;
    logic [31:0]   rdata_q;
    logic          mis_q;

    logic          stall;
    logic          access;
    logic          bad_align;
    logic          ram_we;
    logic [AW-1:0] idx;
    logic          unused_addr;

    logic [31:0]   mem [2**AW];

    assign idx         = addr_q[AW+1:2];
    assign unused_addr = ^bus.addr[31:AW+2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            be_q    <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            be_q    <= be_d;
            if (access && !we_q) begin
                rdata_q <= mem[idx];
            end
            if (access && bad_align) begin
                mis_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        be_d    = be_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.memreq) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_INIT;
                    addr_d  = bus.addr[AW+1:0];
                    wdata_d = bus.wdata;
                    we_d    = bus.memwrite;
                    be_d    = bus.byteen;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        stall  = 1'b0;
        access = 1'b0;
        unique case (state_q)
            S_IDLE: stall = bus.memreq;
            S_WAIT: begin
                stall  = 1'b1;
                access = (cnt_q == 4'd0);
            end
            default: begin
                stall  = 1'b0;
                access = 1'b0;
            end
        endcase
    end

    // Loads are always word accesses; byteen only matters for stores.
    assign bad_align = (!we_q || !be_q)
                     && (addr_q[1:0] != 2'b00);
    assign ram_we    = access && we_q && !bad_align;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            if (be_q) begin
                mem[idx][{addr_q[1:0], 3'b000} +: 8]
                    <= wdata_q[7:0];
            end else begin
                mem[idx] <= wdata_q;
            end
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.stall    = stall;
    assign bus.misalign = mis_q;
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far end of the pipeline's memory-stage interface.
- Accepts load/store requests from the M stage: address from aluoutM, store data from writedataM, byte-store select from storeselectM.
- Holds a word-addressed RAM, services each request after a programmable wait latency, and drives a stall back to the hazard unit while busy.
- Returns full 32-bit read words; byte extraction for loads stays in the datapath.

Parameters:
- AW, 8, word-address width; RAM holds 2^AW 32-bit words.
- LATENCY, 2, number of WAIT cycles per access; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- memreq  input  1  M-stage instruction is a load or store.
- memwrite  input  1  1 = store, 0 = load.
- byteen  input  1  1 = byte store (sb), 0 = word store; ignored for loads.
- addr  input  32  byte address.
- wdata  input  32  store data; for byte stores only wdata[7:0] is meaningful.
- rdata  output  32  word read from RAM; valid in DONE and held afterwards.
- stall  output  1  freeze pipeline; combinational from state and memreq.
- misalign  output  1  sticky flag: a word access was attempted with addr[1:0] != 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counter=0, rdata=0, misalign=0, stall=0.
  - RAM contents are not cleared.
  - Reset asserted mid-transaction aborts it; no RAM write occurs.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If memreq=1, latch addr, wdata, memwrite and byteen.
  - Load counter with LATENCY-1 and go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - Decrement counter each cycle.
  - When counter==0, perform the access on the clock edge and go to DONE.
  - WAIT therefore lasts exactly LATENCY cycles.
- DONE: unconditionally go to IDLE next cycle. The pipeline advances at the end of the DONE cycle.
- stall = (state==IDLE & memreq) | (state==WAIT); 0 in DONE.
  - A request therefore stalls for 1+LATENCY cycles.
  - The instruction completes in its (LATENCY+2)th M-stage cycle.
- Inputs are ignored outside IDLE; memreq dropping during WAIT does not abort the latched request.
- RAM index = latched addr[AW+1:2]. Upper address bits are ignored, so out-of-range addresses wrap silently with no error.
- Load: rdata <= RAM[index] on the WAIT->DONE edge. rdata holds until the next load completes; stores leave rdata unchanged.
- Word store, addr[1:0]==0: RAM[index] <= wdata.
- Byte store:
  - Lane = latched addr[1:0]; RAM[index][8*lane+7 : 8*lane] <= wdata[7:0].
  - Other three bytes are unchanged.
  - Any alignment is legal.
- Misaligned word access (load or store, byteen=0 or load, addr[1:0]!=0):
  - Set misalign=1; no RAM write.
  - Load returns RAM[index] anyway.
  - Timing is unchanged (still goes through WAIT/DONE).
  - misalign clears only on reset.
- Back-to-back requests: a request arriving in IDLE the cycle after DONE is accepted immediately, with no dead cycle beyond DONE.
- Read of a word written by the immediately preceding store returns the new data.

Test Plan:
- Word store then load:
  - Store addr=0x10, wdata=0xDEADBEEF, LATENCY=2; then load addr=0x10.
  - stall high for 3 cycles each.
  - rdata=0xDEADBEEF in the load's DONE cycle.
- Byte lanes:
  - Word store 0x00000000 to 0x20.
  - Byte stores 0x11, 0x22, 0x33, 0x44 to 0x20, 0x21, 0x22, 0x23.
  - Load 0x20 -> rdata=0x44332211.
- Misalign:
  - Word store addr=0x32 wdata=0xFFFFFFFF.
  - misalign=1 after DONE; load 0x30 returns the prior contents unchanged.
  - misalign stays 1 until reset.
- Reset mid-operation:
  - Store to 0x40 begun; reset=0 during WAIT.
  - Outputs go to 0 immediately, state IDLE.
  - Subsequent load 0x40 shows the old value (no write).
- Latency/wrap, LATENCY=1, AW=8:
  - Store 0xA5A5A5A5 to addr 0x400 (wraps to index 0); load addr 0x0 -> 0xA5A5A5A5.
  - stall pulse 2 cycles per request.
  - memreq held low during WAIT does not abort the request.
